// File: rtl/pcis_rd_resp_framer.sv
`timescale 1ns/1ps
// AXI4 read-response framer: queues accepted AR requests and frames exactly
// arlen+1 stream beats per request into R beats tagged with rid/rresp/rlast.
module pcis_rd_resp_framer #(
  parameter int ID_W     = 6,
  parameter int DATA_W   = 512,
  parameter int AR_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ID_W-1:0]             s_arid,
  input  logic [63:0]                 s_araddr,
  input  logic [7:0]                  s_arlen,
  input  logic [2:0]                  s_arsize,
  input  logic                        s_arvalid,
  output logic                        s_arready,
  input  logic [DATA_W-1:0]           s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [ID_W-1:0]             m_rid,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [1:0]                  m_rresp,
  output logic                        m_rlast,
  output logic                        m_rvalid,
  input  logic                        m_rready,
  output logic [$clog2(AR_DEPTH):0]   ar_outstanding,
  output logic [31:0]                 bursts_done
);

  localparam int PTR_W = $clog2(AR_DEPTH);

  logic [ID_W-1:0]   id_mem  [AR_DEPTH];
  logic [7:0]        len_mem [AR_DEPTH];
  logic              err_mem [AR_DEPTH];

  logic [PTR_W:0]    wr_ptr_reg;
  logic [PTR_W:0]    rd_ptr_reg;
  logic [PTR_W:0]    count;
  logic              full;
  logic              head_valid;
  logic              push;
  logic              pop;
  logic [ID_W-1:0]   head_id;
  logic [7:0]        head_len;
  logic              head_err;

  logic [7:0]        beat_cnt_reg;
  logic              out_free;
  logic              load_en;
  logic              load_last;

  logic [ID_W-1:0]   rid_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [1:0]        rresp_reg;
  logic              rlast_reg;
  logic              rvalid_reg;
  logic [31:0]       bursts_done_reg;

  // The address plays no part in framing; data order comes from the stream.
  logic              unused_araddr;
  assign unused_araddr = ^s_araddr;

  // Extra pointer bit distinguishes full from empty.
  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign full       = count[PTR_W];
  assign head_valid = (count != '0);
  assign push       = s_arvalid & ~full;

  assign head_id  = id_mem[rd_ptr_reg[PTR_W-1:0]];
  assign head_len = len_mem[rd_ptr_reg[PTR_W-1:0]];
  assign head_err = err_mem[rd_ptr_reg[PTR_W-1:0]];

  assign out_free  = ~rvalid_reg | m_rready;
  assign load_en   = head_valid & out_free & (head_err | s_axis_tvalid);
  assign load_last = (beat_cnt_reg == head_len);
  assign pop       = load_en & load_last;

  assign s_arready      = ~full;
  assign s_axis_tready  = head_valid & ~head_err & out_free;
  assign ar_outstanding = count;

  assign m_rid       = rid_reg;
  assign m_rdata     = rdata_reg;
  assign m_rresp     = rresp_reg;
  assign m_rlast     = rlast_reg;
  assign m_rvalid    = rvalid_reg;
  assign bursts_done = bursts_done_reg;

  // Request storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr_reg[PTR_W-1:0]]  <= s_arid;
      len_mem[wr_ptr_reg[PTR_W-1:0]] <= s_arlen;
      err_mem[wr_ptr_reg[PTR_W-1:0]] <= (s_arsize != 3'b110);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      beat_cnt_reg    <= '0;
      rid_reg         <= '0;
      rdata_reg       <= '0;
      rresp_reg       <= 2'b00;
      rlast_reg       <= 1'b0;
      rvalid_reg      <= 1'b0;
      bursts_done_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      if (load_en) begin
        rid_reg      <= head_id;
        rdata_reg    <= head_err ? '0 : s_axis_tdata;
        rresp_reg    <= head_err ? 2'b10 : 2'b00;
        rlast_reg    <= load_last;
        rvalid_reg   <= 1'b1;
        beat_cnt_reg <= load_last ? 8'd0 : beat_cnt_reg + 8'd1;
      end else if (m_rready) begin
        rvalid_reg <= 1'b0;
      end

      if (rvalid_reg && m_rready && rlast_reg) begin
        bursts_done_reg <= bursts_done_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pcis_rd_resp_framer.sv
`timescale 1ns/1ps
// Scoreboard bench for pcis_rd_resp_framer: AR issue pushes expected beats,
// a negedge monitor pops and compares every R handshake.
module tb_pcis_rd_resp_framer;

  localparam int ID_W     = 6;
  localparam int DATA_W   = 512;
  localparam int AR_DEPTH = 8;
  localparam int OW       = $clog2(AR_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ID_W-1:0]   s_arid = '0;
  logic [63:0]       s_araddr = '0;
  logic [7:0]        s_arlen = '0;
  logic [2:0]        s_arsize = 3'b110;
  logic              s_arvalid = 1'b0;
  logic              s_arready;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [ID_W-1:0]   m_rid;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;
  logic [OW-1:0]     ar_outstanding;
  logic [31:0]       bursts_done;

  always #5 clk = ~clk;

  pcis_rd_resp_framer #(.ID_W(ID_W), .DATA_W(DATA_W), .AR_DEPTH(AR_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .ar_outstanding(ar_outstanding), .bursts_done(bursts_done)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            err;
    logic            last;
  } beat_t;

  // Reference model: one expected beat per AR beat; non-error beats take the
  // next word of the stream sequence in order.
  beat_t             exp_q[$];
  logic [DATA_W-1:0] model_stream[$];
  logic [DATA_W-1:0] stream_data[$];

  int compared = 0;
  int mismatched = 0;
  int stream_hs = 0;
  int beats_seen = 0;
  int model_bursts = 0;
  int run_len = 0;
  int max_run = 0;
  bit stream_en = 1'b0;
  int gap_pct = 0;
  int rready_mode = 0;
  bit err_watch = 1'b0;
  bit tready_seen = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic push_data(input logic [DATA_W-1:0] d);
    stream_data.push_back(d);
    model_stream.push_back(d);
  endtask

  // Stream source: holds each word until the DUT takes it.
  initial begin
    bit hs;
    bit gap;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    forever begin
      @(negedge clk);
      hs = s_axis_tvalid && s_axis_tready && !rst;
      @(posedge clk);
      #1;
      if (hs && stream_data.size() > 0) begin
        void'(stream_data.pop_front());
        stream_hs++;
      end
      gap = ($urandom_range(99) < gap_pct);
      s_axis_tvalid = stream_en && (stream_data.size() > 0) && !gap;
      s_axis_tdata  = (stream_data.size() > 0) ? stream_data[0] : '0;
    end
  end

  // R-channel ready pattern: 0 always, 1 toggle, 2 random.
  initial begin
    m_rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rready_mode)
        0:       m_rready = 1'b1;
        1:       m_rready = ~m_rready;
        default: m_rready = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor: compares every R handshake and checks hold-stability on stalls.
  logic [ID_W+DATA_W+2:0] held;
  logic [ID_W+DATA_W+2:0] cur;
  logic [DATA_W-1:0]      exp_data;
  logic [1:0]             exp_resp;
  beat_t                  e;
  bit                     exp_ok;
  bit                     stall_prev = 1'b0;

  always @(negedge clk) begin
    cur = {m_rid, m_rdata, m_rresp, m_rlast};
    if (rst) begin
      run_len    = 0;
      stall_prev = 1'b0;
    end else begin
      if (err_watch && s_axis_tready) tready_seen = 1'b1;
      if (stall_prev && m_rvalid) begin
        compared++;
        if (cur !== held) begin
          mismatched++;
          $display("FAIL stall_hold: rid=%0d rresp=%0d rlast=%0b changed while stalled, held rid=%0d rlast=%0b",
                   m_rid, m_rresp, m_rlast, held[DATA_W+ID_W+2:DATA_W+3], held[0]);
        end
      end
      if (m_rvalid && m_rready) begin
        beats_seen++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_beat: got rid=%0d rresp=%0d rlast=%0b, required no beat",
                   m_rid, m_rresp, m_rlast);
        end else begin
          e        = exp_q.pop_front();
          exp_ok   = 1'b1;
          exp_resp = e.err ? 2'b10 : 2'b00;
          if (e.err) exp_data = '0;
          else if (model_stream.size() > 0) exp_data = model_stream.pop_front();
          else begin
            exp_data = '0;
            exp_ok   = 1'b0;
          end
          if (!exp_ok || m_rid !== e.id || m_rdata !== exp_data || m_rresp !== exp_resp || m_rlast !== e.last) begin
            mismatched++;
            $display("FAIL beat: got rid=%0d rresp=%0d rlast=%0b data=%h, required rid=%0d rresp=%0d rlast=%0b data=%h",
                     m_rid, m_rresp, m_rlast, m_rdata, e.id, exp_resp, e.last, exp_data);
          end
          if (e.last) model_bursts++;
        end
      end else begin
        run_len = 0;
      end
      stall_prev = m_rvalid && !m_rready;
      held       = cur;
    end
  end

  task automatic issue_ar(input logic [ID_W-1:0] id, input logic [7:0] len, input logic [2:0] size);
    int  t;
    bit  ok;
    t  = 0;
    ok = 1'b0;
    @(posedge clk);
    #1;
    s_arid    = id;
    s_arlen   = len;
    s_arsize  = size;
    s_araddr  = {$urandom, $urandom};
    s_arvalid = 1'b1;
    while (!ok && t < 2000) begin
      @(negedge clk);
      if (s_arready) ok = 1'b1;
      t++;
    end
    if (ok) begin
      for (int b = 0; b <= int'(len); b++) begin
        exp_q.push_back('{id: id, err: (size != 3'b110), last: (b == int'(len))});
      end
    end else begin
      check("ar_accept_timeout", 64'(ok), 64'd1);
    end
    @(posedge clk);
    #1;
    s_arvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    check({name, "_drained_left"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_bursts_done"}, 64'(bursts_done), 64'(model_bursts));
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    s_arvalid = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_stream.delete();
    stream_data.delete();
    model_bursts = 0;
    check("rst_arready", 64'(s_arready), 64'd1);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_rlast", 64'(m_rlast), 64'd0);
    check("rst_rid", 64'(m_rid), 64'd0);
    check("rst_rresp", 64'(m_rresp), 64'd0);
    check("rst_rdata_zero", 64'(m_rdata === '0), 64'd1);
    check("rst_outstanding", 64'(ar_outstanding), 64'd0);
    check("rst_bursts_done", 64'(bursts_done), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int base;
    int t;
    int nerr_beats;
    logic [7:0]  rl;
    logic [2:0]  rs;

    apply_reset();
    stream_en   = 1'b1;
    rready_mode = 0;

    // Single burst, with first-beat latency checks.
    for (int i = 1; i <= 4; i++) push_data(DATA_W'(i));
    base = stream_hs;
    issue_ar(6'd5, 8'd3, 3'b110);
    check("lat_head_tready", 64'(s_axis_tready), 64'd1);
    check("lat_rvalid_low", 64'(m_rvalid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_rvalid_high", 64'(m_rvalid), 64'd1);
    wait_drain("single", 200);
    check("single_stream_beats", 64'(stream_hs - base), 64'd4);
    check("single_bursts_one", 64'(bursts_done), 64'd1);

    // Queue fill with the stream idle, then a blocked push while full.
    stream_en = 1'b0;
    for (int i = 0; i < 8; i++) issue_ar(ID_W'(i), 8'd0, 3'b110);
    check("full_arready", 64'(s_arready), 64'd0);
    check("full_outstanding", 64'(ar_outstanding), 64'd8);
    s_arid    = 6'd63;
    s_arvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_arvalid = 1'b0;
    check("full_no_push", 64'(ar_outstanding), 64'd8);
    for (int i = 0; i < 8; i++) push_data(rand_data());
    stream_en = 1'b1;
    wait_drain("fill", 300);
    check("fill_outstanding_after", 64'(ar_outstanding), 64'd0);

    // Backpressure: m_rready toggles every cycle.
    rready_mode = 1;
    for (int i = 0; i < 8; i++) push_data(rand_data());
    base = stream_hs;
    issue_ar(6'd21, 8'd7, 3'b110);
    wait_drain("bp", 300);
    check("bp_stream_beats", 64'(stream_hs - base), 64'd8);
    rready_mode = 0;

    // Error burst must leave pending stream data untouched.
    push_data(DATA_W'(8'hAA));
    repeat (3) @(posedge clk);
    base        = stream_hs;
    tready_seen = 1'b0;
    err_watch   = 1'b1;
    issue_ar(6'd9, 8'd1, 3'b011);
    wait_drain("err", 200);
    err_watch = 1'b0;
    check("err_tready_seen", 64'(tready_seen), 64'd0);
    check("err_stream_beats", 64'(stream_hs - base), 64'd0);
    check("err_pending_words", 64'(stream_data.size()), 64'd1);
    issue_ar(6'd10, 8'd0, 3'b110);
    wait_drain("after_err", 200);
    check("after_err_stream_beats", 64'(stream_hs - base), 64'd1);

    // Max length followed by a single-beat burst, no bubbles.
    for (int i = 0; i < 257; i++) push_data(rand_data());
    max_run = 0;
    issue_ar(6'd11, 8'd255, 3'b110);
    issue_ar(6'd12, 8'd0, 3'b110);
    wait_drain("maxlen", 1000);
    check("maxlen_consecutive", 64'(max_run), 64'd257);

    // Reset in the middle of a 16-beat burst.
    for (int i = 0; i < 16; i++) push_data(rand_data());
    base = beats_seen;
    issue_ar(6'd13, 8'd15, 3'b110);
    t = 0;
    while ((beats_seen - base) < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("midrst_beats_before", 64'((beats_seen - base) >= 5), 64'd1);
    apply_reset();
    base = beats_seen;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_more_beats", 64'(beats_seen - base), 64'd0);
    check("midrst_outstanding", 64'(ar_outstanding), 64'd0);
    for (int i = 0; i < 3; i++) push_data(rand_data());
    issue_ar(6'd14, 8'd2, 3'b110);
    wait_drain("recover", 200);

    // Randomized mix of lengths, ids, error sizes, gaps and backpressure.
    rready_mode = 2;
    gap_pct     = 30;
    base        = stream_hs;
    nerr_beats  = 0;
    for (int n = 0; n < 30; n++) begin
      rl = 8'($urandom_range(15));
      rs = ($urandom_range(9) == 0) ? 3'b011 : 3'b110;
      if (rs == 3'b110) begin
        for (int i = 0; i <= int'(rl); i++) push_data(rand_data());
        nerr_beats += int'(rl) + 1;
      end
      issue_ar(ID_W'($urandom), rl, rs);
    end
    wait_drain("random", 5000);
    check("random_stream_beats", 64'(stream_hs - base), 64'(nerr_beats));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcis_rd_resp_framer.md
# pcis_rd_resp_framer

Converts the 512-bit data stream leaving the 64-to-512 width converter into protocol-correct AXI4 read responses on the DMA PCIS slave port. It queues accepted read-address requests, then drains exactly `arlen+1` stream beats per request, tagging each with the request's `arid` and asserting `rlast` on the final beat. This replaces fixed-count `rlast` generation. It sits between the output width converter and the PCIS read-data channel.

## Interface
- `ID_W`, 6: AXI ID width.
- `DATA_W`, 512: data width, stream and R channel.
- `AR_DEPTH`, 8: read-request queue depth, power of two ≥ 2.
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_arid`  in  ID_W  read ID.
- `s_araddr`  in  64  read address; not used for data selection.
- `s_arlen`  in  8  beats minus one.
- `s_arsize`  in  3  beat size.
- `s_arvalid`  in  1  AR valid.
- `s_arready`  out  1  AR ready.
- `s_axis_tdata`  in  DATA_W  stream data from the width converter.
- `s_axis_tvalid`  in  1  stream valid.
- `s_axis_tready`  out  1  stream ready.
- `m_rid`  out  ID_W  response ID.
- `m_rdata`  out  DATA_W  response data.
- `m_rresp`  out  2  response code.
- `m_rlast`  out  1  last beat of burst.
- `m_rvalid`  out  1  R valid.
- `m_rready`  in  1  R ready.
- `ar_outstanding`  out  $clog2(AR_DEPTH)+1  number of queued requests, including the one being served.
- `bursts_done`  out  32  completed bursts; wraps modulo 2^32.

## Operation
- **AR queue.** The queue is a FIFO of {`arid`, `arlen`, err}, where err = (`s_arsize` != 3'b110).
  - `s_arready` = !full.
  - A push happens on `s_arvalid & s_arready`.
  - While full, no push occurs, even in a cycle that pops.
- **Head request.** The FIFO head is the active burst. `beat_cnt` (8 bits) counts the beats already loaded into the output register for that burst.
- **Output register.** A single register holds {rid, rdata, rresp, rlast}.
  - load_en = head_valid & (!m_rvalid | m_rready) & (head.err | s_axis_tvalid).
  - A load captures rid = head.id.
  - rlast = (beat_cnt == head.len).
  - rresp = head.err ? 2'b10 : 2'b00.
  - rdata = head.err ? 0 : `s_axis_tdata`.
- **Stream consumption.** `s_axis_tready` = head_valid & !head.err & (!m_rvalid | m_rready).
  - Error bursts never consume stream beats.
- **Per-load bookkeeping.**
  - On a load, `beat_cnt` increments.
  - If the load is the rlast beat, `beat_cnt` is cleared to 0 and the head is popped in the same cycle.
- **Output valid.** `m_rvalid` is set on load and cleared on `m_rready` without a load.
- **Completion counter.** `bursts_done` increments on the handshake of a beat with `m_rlast` = 1.
- **Occupancy.** `ar_outstanding` = FIFO occupancy.
- **Reset values** (all outputs and state):
  - `s_arready` = 1.
  - `s_axis_tready` = 0.
  - `m_rvalid` = 0.
  - `m_rlast` = 0.
  - `m_rid`, `m_rdata`, `m_rresp` = 0.
  - `ar_outstanding` = 0.
  - `bursts_done` = 0.
  - `beat_cnt` = 0.
  - FIFO empty.
- **Reset mid-burst.** Everything is discarded and no further beats of that burst are produced. Upstream stream blocks share `rst`.

## Timing
- **Latency.** With AR accepted at edge k and stream data already valid:
  - the head is valid after edge k;
  - the first beat loads at edge k+1;
  - `m_rvalid` is high after edge k+1.
- **Throughput.** 1 beat/cycle while `m_rready` = 1 and `s_axis_tvalid` = 1.
- **Back-to-back bursts.** The next burst's first beat loads in the cycle right after the previous rlast load, with no bubble.
- **Stalls.** Output data is held stable while `m_rvalid & !m_rready`.
- **Outputs.** `s_axis_tready` and `s_arready` are combinational from registered state and `m_rready`. No combinational path exists from `s_axis_tvalid` to `s_axis_tready`.
- **Boundary cases.**
  - `arlen` = 0 gives a single beat with rlast = 1.
  - `arlen` = 255 gives 256 beats; `beat_cnt` reaches 255 and then clears.
  - Empty queue: no stream beats are consumed, so the stream backs up.

## Test plan
- **Single burst, beat count.**
  - Stimulus: reset, then AR id=5, len=3, size=6; stream 0x1..0x4, `m_rready`=1.
  - Required: 4 beats with rid=5, rresp=0, data 0x1..0x4, rlast only on the 4th; `bursts_done`=1.
- **Queue fill and drain.**
  - Stimulus: issue 8 ARs (ids 0..7, len=0) with the stream idle.
  - Required: `s_arready`=0 after the 8th, `ar_outstanding`=8.
  - Then: supply 8 beats.
  - Required: responses return in id order 0..7.
- **Backpressure.**
  - Stimulus: len=7 burst, `m_rready` toggling 1/0 each cycle.
  - Required: rdata, rid and rlast stable while stalled; no beat lost or duplicated; exactly 8 stream beats consumed.
- **Error burst.**
  - Stimulus: AR size=3, len=1, with the stream holding data 0xAA.
  - Required: 2 beats with rresp=2'b10, rdata=0; `s_axis_tready` stays 0; 0xAA is still pending for the next valid burst.
- **Max length and back-to-back.**
  - Stimulus: AR len=255 then len=0, `m_rready`=1.
  - Required: 257 beats on consecutive cycles, rlast on beats 256 and 257.
- **Reset mid-burst.**
  - Stimulus: len=15 burst, assert `rst` after 5 beats.
  - Required: all reset values the next cycle; `ar_outstanding`=0.
